// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - opcode constants, control encodings and the ID/EX control bundle
package ctrl_pkg;

  localparam int CTRL_REG_AW    = 5;
  localparam int CTRL_IMM_SRC_W = 3;
  localparam int CTRL_ALU_OP_W  = 2;
  localparam int CTRL_RES_W     = 2;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [CTRL_IMM_SRC_W-1:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100
  } imm_src_t;

  typedef enum logic [CTRL_ALU_OP_W-1:0] {
    ALU_ADD    = 2'b00,
    ALU_BRANCH = 2'b01,
    ALU_FUNCT  = 2'b10,
    ALU_PASS_B = 2'b11
  } alu_op_t;

  typedef enum logic [CTRL_RES_W-1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } res_src_t;

  typedef struct packed {
    logic     alu_src_a;
    logic     alu_src;
    alu_op_t  alu_op;
    res_src_t result_src;
    logic     mem_read;
    logic     mem_write;
    logic     reg_write;
    logic     branch;
    logic     jump;
    logic     jalr;
  } ctrl_bundle_t;

  localparam ctrl_bundle_t BUBBLE = '0;

endpackage

// File: rtl/pipelined_control_unit_if.sv
// rtl/pipelined_control_unit_if.sv - datapath <-> control unit bundle
// fwd_a_e/fwd_b_e exist only when CTRL_FWD_EN is defined.
interface pipelined_control_unit_if
  import ctrl_pkg::*;
#(
  parameter int REG_AW    = CTRL_REG_AW,
  parameter int IMM_SRC_W = CTRL_IMM_SRC_W,
  parameter int ALU_OP_W  = CTRL_ALU_OP_W
);
  logic [6:0]           op_d;
  logic [REG_AW-1:0]    rs1_d, rs2_d, rd_d;
  logic                 branch_taken_e;
  logic [IMM_SRC_W-1:0] ImmSrc_d;
  logic                 illegal_d;
  logic                 stall_f, stall_d, flush_d, flush_e;
  logic                 ALUSrcA_e, ALUSrc_e, Branch_e, Jump_e, Jalr_e;
  logic [ALU_OP_W-1:0]  ALUOp_e;
  logic [REG_AW-1:0]    rs1_e, rs2_e, rd_e;
  logic                 MemWrite_m, MemRead_m, RegWrite_m;
  logic [1:0]           ResultSrc_m;
  logic [REG_AW-1:0]    rd_m;
  logic                 RegWrite_w;
  logic [1:0]           ResultSrc_w;
  logic [REG_AW-1:0]    rd_w;
`ifdef CTRL_FWD_EN
  logic [1:0]           fwd_a_e, fwd_b_e;
`endif

  modport master (
    output op_d, rs1_d, rs2_d, rd_d, branch_taken_e,
`ifdef CTRL_FWD_EN
    input  fwd_a_e, fwd_b_e,
`endif
    input  ImmSrc_d, illegal_d, stall_f, stall_d, flush_d, flush_e,
    input  ALUSrcA_e, ALUSrc_e, Branch_e, Jump_e, Jalr_e, ALUOp_e, rs1_e, rs2_e, rd_e,
    input  MemWrite_m, MemRead_m, RegWrite_m, ResultSrc_m, rd_m,
    input  RegWrite_w, ResultSrc_w, rd_w
  );

  modport slave (
    input  op_d, rs1_d, rs2_d, rd_d, branch_taken_e,
`ifdef CTRL_FWD_EN
    output fwd_a_e, fwd_b_e,
`endif
    output ImmSrc_d, illegal_d, stall_f, stall_d, flush_d, flush_e,
    output ALUSrcA_e, ALUSrc_e, Branch_e, Jump_e, Jalr_e, ALUOp_e, rs1_e, rs2_e, rd_e,
    output MemWrite_m, MemRead_m, RegWrite_m, ResultSrc_m, rd_m,
    output RegWrite_w, ResultSrc_w, rd_w
  );
endinterface

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - load-use/RAW stall, redirect flush and (CTRL_FWD_EN) forward selects
module hazard_unit #(
  parameter int REG_AW = 5
) (
  input  logic              i_use_rs1,
  input  logic              i_use_rs2,
  input  logic [REG_AW-1:0] i_rs1_d,
  input  logic [REG_AW-1:0] i_rs2_d,
  input  logic [REG_AW-1:0] i_rd_e,
  input  logic              i_reg_write_m,
  input  logic [REG_AW-1:0] i_rd_m,
  input  logic              i_branch_taken_e,
`ifdef CTRL_FWD_EN
  input  logic              i_mem_read_e,
  input  logic [REG_AW-1:0] i_rs1_e,
  input  logic [REG_AW-1:0] i_rs2_e,
  input  logic              i_reg_write_w,
  input  logic [REG_AW-1:0] i_rd_w,
  output logic [1:0]        o_fwd_a_e,
  output logic [1:0]        o_fwd_b_e,
`else
  input  logic              i_reg_write_e,
`endif
  output logic              o_stall_f,
  output logic              o_stall_d,
  output logic              o_flush_d,
  output logic              o_flush_e
);
  logic w_hit_e;
  logic w_lw_stall;

  assign w_hit_e = (i_rd_e != '0) &&
                   ((i_use_rs1 && (i_rs1_d == i_rd_e)) || (i_use_rs2 && (i_rs2_d == i_rd_e)));

`ifdef CTRL_FWD_EN
  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs,
                                         input logic wm, input logic [REG_AW-1:0] rdm,
                                         input logic ww, input logic [REG_AW-1:0] rdw);
    if (wm && (rdm != '0) && (rdm == rs))      return 2'b10;
    else if (ww && (rdw != '0) && (rdw == rs)) return 2'b01;
    else                                       return 2'b00;
  endfunction

  assign w_lw_stall = i_mem_read_e & w_hit_e;
  assign o_fwd_a_e  = fwd_sel(i_rs1_e, i_reg_write_m, i_rd_m, i_reg_write_w, i_rd_w);
  assign o_fwd_b_e  = fwd_sel(i_rs2_e, i_reg_write_m, i_rd_m, i_reg_write_w, i_rd_w);
`else
  // Without a bypass network every in-flight writer ahead of WB must drain first.
  logic w_hit_m;
  assign w_hit_m = (i_rd_m != '0) &&
                   ((i_use_rs1 && (i_rs1_d == i_rd_m)) || (i_use_rs2 && (i_rs2_d == i_rd_m)));
  assign w_lw_stall = (i_reg_write_e & w_hit_e) | (i_reg_write_m & w_hit_m);
`endif

  assign o_stall_f = w_lw_stall & ~i_branch_taken_e;
  assign o_stall_d = w_lw_stall & ~i_branch_taken_e;
  assign o_flush_d = i_branch_taken_e;
  assign o_flush_e = w_lw_stall | i_branch_taken_e;
endmodule

// File: rtl/pipelined_control_unit.sv
// rtl/pipelined_control_unit.sv - ID decode plus ID/EX, EX/MEM, MEM/WB control registers
// Forwarding selects are built when CTRL_FWD_EN is defined.
module pipelined_control_unit
  import ctrl_pkg::*;
#(
  parameter int REG_AW    = CTRL_REG_AW,
  parameter int IMM_SRC_W = CTRL_IMM_SRC_W,
  parameter int ALU_OP_W  = CTRL_ALU_OP_W
) (
  input logic                     clk,
  input logic                     rst,
  pipelined_control_unit_if.slave bus
);
  ctrl_bundle_t         w_ctrl_d;
  logic [IMM_SRC_W-1:0] w_imm_src;
  logic                 w_illegal, w_use_rs1, w_use_rs2, w_flush_e;

  ctrl_bundle_t         r_ctrl_e;
  logic [REG_AW-1:0]    r_rs1_e, r_rs2_e, r_rd_e;
  logic                 r_mem_write_m, r_mem_read_m, r_reg_write_m;
  logic [1:0]           r_result_src_m;
  logic [REG_AW-1:0]    r_rd_m;
  logic                 r_reg_write_w;
  logic [1:0]           r_result_src_w;
  logic [REG_AW-1:0]    r_rd_w;

  always_comb begin
    w_ctrl_d  = BUBBLE;
    w_imm_src = IMM_SRC_W'(IMM_I);
    w_illegal = 1'b0;
    w_use_rs1 = 1'b1;
    w_use_rs2 = 1'b0;
    case (bus.op_d)
      OP_LOAD: begin
        w_ctrl_d.alu_src = 1'b1; w_ctrl_d.result_src = RES_MEM;
        w_ctrl_d.mem_read = 1'b1; w_ctrl_d.reg_write = 1'b1;
      end
      OP_STORE: begin
        w_imm_src = IMM_SRC_W'(IMM_S); w_ctrl_d.alu_src = 1'b1;
        w_ctrl_d.mem_write = 1'b1; w_use_rs2 = 1'b1;
      end
      OP_RTYPE: begin
        w_ctrl_d.alu_op = ALU_FUNCT; w_ctrl_d.reg_write = 1'b1; w_use_rs2 = 1'b1;
      end
      OP_IALU: begin
        w_ctrl_d.alu_src = 1'b1; w_ctrl_d.alu_op = ALU_FUNCT; w_ctrl_d.reg_write = 1'b1;
      end
      OP_BRANCH: begin
        w_imm_src = IMM_SRC_W'(IMM_B); w_ctrl_d.alu_op = ALU_BRANCH;
        w_ctrl_d.branch = 1'b1; w_use_rs2 = 1'b1;
      end
      OP_JAL: begin
        w_imm_src = IMM_SRC_W'(IMM_J); w_ctrl_d.result_src = RES_PC4;
        w_ctrl_d.reg_write = 1'b1; w_ctrl_d.jump = 1'b1; w_use_rs1 = 1'b0;
      end
      OP_JALR: begin
        w_ctrl_d.alu_src = 1'b1; w_ctrl_d.result_src = RES_PC4;
        w_ctrl_d.reg_write = 1'b1; w_ctrl_d.jalr = 1'b1;
      end
      OP_LUI: begin
        w_imm_src = IMM_SRC_W'(IMM_U); w_ctrl_d.alu_src = 1'b1;
        w_ctrl_d.alu_op = ALU_PASS_B; w_ctrl_d.reg_write = 1'b1; w_use_rs1 = 1'b0;
      end
      OP_AUIPC: begin
        w_imm_src = IMM_SRC_W'(IMM_U); w_ctrl_d.alu_src_a = 1'b1; w_ctrl_d.alu_src = 1'b1;
        w_ctrl_d.reg_write = 1'b1; w_use_rs1 = 1'b0;
      end
      default: w_illegal = 1'b1;
    endcase
  end

  hazard_unit #(.REG_AW(REG_AW)) u_hazard (
    .i_use_rs1        (w_use_rs1),
    .i_use_rs2        (w_use_rs2),
    .i_rs1_d          (bus.rs1_d),
    .i_rs2_d          (bus.rs2_d),
    .i_rd_e           (r_rd_e),
    .i_reg_write_m    (r_reg_write_m),
    .i_rd_m           (r_rd_m),
    .i_branch_taken_e (bus.branch_taken_e),
`ifdef CTRL_FWD_EN
    .i_mem_read_e     (r_ctrl_e.mem_read),
    .i_rs1_e          (r_rs1_e),
    .i_rs2_e          (r_rs2_e),
    .i_reg_write_w    (r_reg_write_w),
    .i_rd_w           (r_rd_w),
    .o_fwd_a_e        (bus.fwd_a_e),
    .o_fwd_b_e        (bus.fwd_b_e),
`else
    .i_reg_write_e    (r_ctrl_e.reg_write),
`endif
    .o_stall_f        (bus.stall_f),
    .o_stall_d        (bus.stall_d),
    .o_flush_d        (bus.flush_d),
    .o_flush_e        (w_flush_e)
  );

  // EX/MEM and MEM/WB never stall; only ID/EX can be turned into a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ctrl_e       <= BUBBLE;
      r_rs1_e        <= '0;
      r_rs2_e        <= '0;
      r_rd_e         <= '0;
      r_mem_write_m  <= 1'b0;
      r_mem_read_m   <= 1'b0;
      r_reg_write_m  <= 1'b0;
      r_result_src_m <= '0;
      r_rd_m         <= '0;
      r_reg_write_w  <= 1'b0;
      r_result_src_w <= '0;
      r_rd_w         <= '0;
    end else begin
      if (w_flush_e) begin
        r_ctrl_e <= BUBBLE;
        r_rs1_e  <= '0;
        r_rs2_e  <= '0;
        r_rd_e   <= '0;
      end else begin
        r_ctrl_e <= w_ctrl_d;
        r_rs1_e  <= bus.rs1_d;
        r_rs2_e  <= bus.rs2_d;
        r_rd_e   <= bus.rd_d;
      end
      r_mem_write_m  <= r_ctrl_e.mem_write;
      r_mem_read_m   <= r_ctrl_e.mem_read;
      r_reg_write_m  <= r_ctrl_e.reg_write;
      r_result_src_m <= r_ctrl_e.result_src;
      r_rd_m         <= r_rd_e;
      r_reg_write_w  <= r_reg_write_m;
      r_result_src_w <= r_result_src_m;
      r_rd_w         <= r_rd_m;
    end
  end

  assign bus.ImmSrc_d    = w_imm_src;
  assign bus.illegal_d   = w_illegal;
  assign bus.flush_e     = w_flush_e;
  assign bus.ALUSrcA_e   = r_ctrl_e.alu_src_a;
  assign bus.ALUSrc_e    = r_ctrl_e.alu_src;
  assign bus.ALUOp_e     = ALU_OP_W'(r_ctrl_e.alu_op);
  assign bus.Branch_e    = r_ctrl_e.branch;
  assign bus.Jump_e      = r_ctrl_e.jump;
  assign bus.Jalr_e      = r_ctrl_e.jalr;
  assign bus.rs1_e       = r_rs1_e;
  assign bus.rs2_e       = r_rs2_e;
  assign bus.rd_e        = r_rd_e;
  assign bus.MemWrite_m  = r_mem_write_m;
  assign bus.MemRead_m   = r_mem_read_m;
  assign bus.RegWrite_m  = r_reg_write_m;
  assign bus.ResultSrc_m = r_result_src_m;
  assign bus.rd_m        = r_rd_m;
  assign bus.RegWrite_w  = r_reg_write_w;
  assign bus.ResultSrc_w = r_result_src_w;
  assign bus.rd_w        = r_rd_w;
endmodule

// File: tb/tb_pipelined_control_unit.sv
// tb/tb_pipelined_control_unit.sv - random + directed stream against a stage-list pipeline model
// Model and checks follow CTRL_FWD_EN the same way the RTL does.
module tb_pipelined_control_unit;

  typedef struct {
    logic [6:0] op;
    logic [4:0] rs1, rs2, rd;
    logic       tk;
  } instr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  instr_t id_s, ex_s, mem_s, wb_s;
  instr_t dq[$];

  pipelined_control_unit_if bus ();
  pipelined_control_unit dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // {ImmSrc, ALUSrcA, ALUSrc, ALUOp, ResultSrc, MemRead, MemWrite, RegWrite, Branch, Jump, Jalr}
  function automatic logic [14:0] ref_ctrl(input logic [6:0] op);
    case (op)
      7'b0000011: return 15'b000_0_1_00_01_1_0_1_0_0_0;
      7'b0100011: return 15'b001_0_1_00_00_0_1_0_0_0_0;
      7'b0110011: return 15'b000_0_0_10_00_0_0_1_0_0_0;
      7'b0010011: return 15'b000_0_1_10_00_0_0_1_0_0_0;
      7'b1100011: return 15'b010_0_0_01_00_0_0_0_1_0_0;
      7'b1101111: return 15'b011_0_0_00_10_0_0_1_0_1_0;
      7'b1100111: return 15'b000_0_1_00_10_0_0_1_0_0_1;
      7'b0110111: return 15'b100_0_1_11_00_0_0_1_0_0_0;
      7'b0010111: return 15'b100_1_1_00_00_0_0_1_0_0_0;
      default:    return 15'b0;
    endcase
  endfunction

  function automatic logic ref_illegal(input logic [6:0] op);
    return !(op inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                        7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111});
  endfunction

  function automatic logic uses_rs1(input logic [6:0] op);
    return !(op inside {7'b1101111, 7'b0110111, 7'b0010111});
  endfunction

  function automatic logic uses_rs2(input logic [6:0] op);
    return op inside {7'b0110011, 7'b0100011, 7'b1100011};
  endfunction

  function automatic logic writes(input instr_t s);
    logic [14:0] c;
    c = ref_ctrl(s.op);
    return c[3];
  endfunction

  function automatic logic hits(input instr_t p, input instr_t d);
    return writes(p) && (p.rd != 5'd0) &&
           ((uses_rs1(d.op) && d.rs1 == p.rd) || (uses_rs2(d.op) && d.rs2 == p.rd));
  endfunction

  function automatic logic taken(input instr_t s);
    if (s.op == 7'b1100011) return s.tk;
    return (s.op == 7'b1101111) || (s.op == 7'b1100111);
  endfunction

  function automatic instr_t mk(input logic [6:0] op, input logic [4:0] rs1, rs2, rd,
                                input logic tk);
    instr_t s;
    s.op = op; s.rs1 = rs1; s.rs2 = rs2; s.rd = rd; s.tk = tk;
    return s;
  endfunction

  function automatic instr_t bubble();
    return mk(7'd0, 5'd0, 5'd0, 5'd0, 1'b0);
  endfunction

`ifdef CTRL_FWD_EN
  function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
    if (writes(mem_s) && mem_s.rd != 5'd0 && mem_s.rd == rs) return 2'b10;
    if (writes(wb_s) && wb_s.rd != 5'd0 && wb_s.rd == rs)    return 2'b01;
    return 2'b00;
  endfunction
`endif

  function automatic instr_t rand_instr();
    logic [6:0] ops [9];
    int k;
    ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
            7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
    k = $urandom_range(0, 9);
    return mk((k == 9) ? (($urandom_range(0, 1) == 1) ? 7'h7F : 7'h73) : ops[k],
              5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
  endfunction

  function automatic instr_t fetch();
    if (dq.size() > 0) return dq.pop_front();
    return rand_instr();
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_e"}, 32'({bus.ALUSrcA_e, bus.ALUSrc_e, bus.ALUOp_e, bus.Branch_e, bus.Jump_e,
                            bus.Jalr_e, bus.rs1_e, bus.rs2_e, bus.rd_e}), 32'd0);
    check({tag, "_m"}, 32'({bus.MemWrite_m, bus.MemRead_m, bus.RegWrite_m, bus.ResultSrc_m,
                            bus.rd_m}), 32'd0);
    check({tag, "_w"}, 32'({bus.RegWrite_w, bus.ResultSrc_w, bus.rd_w}), 32'd0);
    check({tag, "_hz"}, 32'({bus.stall_f, bus.stall_d, bus.flush_d, bus.flush_e}), 32'd0);
`ifdef CTRL_FWD_EN
    check({tag, "_fwd"}, 32'({bus.fwd_a_e, bus.fwd_b_e}), 32'd0);
`endif
  endtask

  task automatic cycle();
    logic        lw, bt;
    logic [14:0] cd, ce, cm, cw;
    @(negedge clk);
    bus.op_d = id_s.op; bus.rs1_d = id_s.rs1; bus.rs2_d = id_s.rs2; bus.rd_d = id_s.rd;
    bt = taken(ex_s);
    bus.branch_taken_e = bt;
    #1;
`ifdef CTRL_FWD_EN
    lw = writes(ex_s) && (ex_s.op == 7'b0000011) && hits(ex_s, id_s);
`else
    lw = hits(ex_s, id_s) || hits(mem_s, id_s);
`endif
    cd = ref_ctrl(id_s.op);
    ce = ref_ctrl(ex_s.op);
    cm = ref_ctrl(mem_s.op);
    cw = ref_ctrl(wb_s.op);
    check("stall_f", 32'(bus.stall_f), 32'(lw && !bt));
    check("stall_d", 32'(bus.stall_d), 32'(lw && !bt));
    check("flush_d", 32'(bus.flush_d), 32'(bt));
    check("flush_e", 32'(bus.flush_e), 32'(lw || bt));
    check("illegal_d", 32'(bus.illegal_d), 32'(ref_illegal(id_s.op)));
    check("ImmSrc_d", 32'(bus.ImmSrc_d), 32'(cd[14:12]));
    check("ctrl_e", 32'({bus.ALUSrcA_e, bus.ALUSrc_e, bus.ALUOp_e, bus.Branch_e, bus.Jump_e,
                         bus.Jalr_e}), 32'({ce[11], ce[10], ce[9:8], ce[2], ce[1], ce[0]}));
    check("regs_e", 32'({bus.rs1_e, bus.rs2_e, bus.rd_e}), 32'({ex_s.rs1, ex_s.rs2, ex_s.rd}));
    check("ctrl_m", 32'({bus.MemWrite_m, bus.MemRead_m, bus.RegWrite_m, bus.ResultSrc_m}),
          32'({cm[4], cm[5], cm[3], cm[7:6]}));
    check("rd_m", 32'(bus.rd_m), 32'(mem_s.rd));
    check("ctrl_w", 32'({bus.RegWrite_w, bus.ResultSrc_w}), 32'({cw[3], cw[7:6]}));
    check("rd_w", 32'(bus.rd_w), 32'(wb_s.rd));
`ifdef CTRL_FWD_EN
    check("fwd_a_e", 32'(bus.fwd_a_e), 32'(ref_fwd(ex_s.rs1)));
    check("fwd_b_e", 32'(bus.fwd_b_e), 32'(ref_fwd(ex_s.rs2)));
`endif
    wb_s  = mem_s;
    mem_s = ex_s;
    ex_s  = (lw || bt) ? bubble() : id_s;
    if (!(lw && !bt)) id_s = fetch();
  endtask

  task automatic reset_mid();
    @(negedge clk);
    #2;
    rst = 1'b1;
    bus.branch_taken_e = 1'b0;
    #1;
    check_zero("rst_mid");
    ex_s = bubble(); mem_s = bubble(); wb_s = bubble();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic found;
    bus.op_d = '0; bus.rs1_d = '0; bus.rs2_d = '0; bus.rd_d = '0; bus.branch_taken_e = 1'b0;
    ex_s = bubble(); mem_s = bubble(); wb_s = bubble();
    #1;
    check_zero("rst_init");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // decode sweep; jal/jalr last so their redirects only kill fillers
    dq.push_back(mk(7'b0000011, 0, 0, 1, 0));
    dq.push_back(mk(7'b0100011, 0, 0, 2, 0));
    dq.push_back(mk(7'b0110011, 0, 0, 3, 0));
    dq.push_back(mk(7'b0010011, 0, 0, 4, 0));
    dq.push_back(mk(7'b1100011, 0, 0, 5, 0));
    dq.push_back(mk(7'b0110111, 0, 0, 6, 0));
    dq.push_back(mk(7'b0010111, 0, 0, 7, 0));
    dq.push_back(mk(7'h7F,      0, 0, 8, 0));
    dq.push_back(mk(7'b1101111, 0, 0, 9, 0));
    dq.push_back(mk(7'b0010011, 0, 0, 10, 0));
    dq.push_back(mk(7'b1100111, 0, 0, 11, 0));
    dq.push_back(mk(7'b0010011, 0, 0, 12, 0));
    dq.push_back(mk(7'b0010011, 0, 0, 13, 0));
    // load-use, lw x0, lw x5 then lui x5
    dq.push_back(mk(7'b0000011, 1, 0, 5, 0));
    dq.push_back(mk(7'b0110011, 5, 1, 6, 0));
    dq.push_back(mk(7'b0000011, 1, 0, 0, 0));
    dq.push_back(mk(7'b0110011, 0, 0, 6, 0));
    dq.push_back(mk(7'b0000011, 1, 0, 5, 0));
    dq.push_back(mk(7'b0110111, 5, 5, 5, 0));
    // taken beq in EX while ID holds a consumer of the older load
    dq.push_back(mk(7'b0000011, 1, 0, 5, 0));
    dq.push_back(mk(7'b1100011, 0, 0, 0, 1));
    dq.push_back(mk(7'b0110011, 5, 1, 6, 0));
    // sub x3 then add x3, consumer of x3
    dq.push_back(mk(7'b0110011, 1, 2, 3, 0));
    dq.push_back(mk(7'b0110011, 1, 2, 3, 0));
    dq.push_back(mk(7'b0110011, 3, 0, 9, 0));
    id_s = fetch();

    repeat (40) cycle();
    repeat (300) cycle();

    dq.push_back(mk(7'b0000011, 1, 0, 5, 0));
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      cycle();
      if (ex_s.op == 7'b0000011) found = 1'b1;
      else if (dq.size() == 0 && id_s.op != 7'b0000011) dq.push_back(mk(7'b0000011, 1, 0, 5, 0));
    end
    check("lw_reaches_ex", 32'(found), 32'd1);
    reset_mid();

    repeat (200) cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
